// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   - RV32M funct3 op codes (OP_MUL .. OP_REMU)
//   - FSM state encoding (state_e). CHK exists only when the
//     MULDIV_EARLY_OUT_EN macro is defined.
//   - XLEN_DEFAULT operand width
//   - magnitude(): absolute value for signed divide operands
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    DONE = 3'd3
`ifdef MULDIV_EARLY_OUT_EN
    , CHK = 3'd4
`endif
  } state_e;

  // Signed divide ops: DIV and REM. The unsigned ones have funct3[0] set.
  function automatic logic is_signed_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Two's-complement magnitude. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude of the most negative value.
  function automatic logic [XLEN_DEFAULT-1:0] magnitude(
    input logic [XLEN_DEFAULT-1:0] v,
    input logic                    is_signed
  );
    return (is_signed && v[XLEN_DEFAULT-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division step.
//   rem      : partial remainder (always < divisor on entry)
//   quo      : quotient register; its MSB is the next dividend bit to
//              shift in, its LSB receives the new quotient bit
//   divisor  : divisor magnitude (non-zero)
//   next_rem : remainder after shift-and-conditional-subtract
//   next_quo : quotient shifted left with the new quotient bit appended
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic [XLEN-1:0] next_quo
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // shifted < 2*divisor, so (shifted - divisor) lies strictly inside
  // (-divisor, divisor) and bit XLEN of the difference is a clean borrow.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      next_rem = diff[XLEN-1:0];
      next_quo = {quo[XLEN-2:0], 1'b1};
    end else begin
      next_rem = shifted[XLEN-1:0];
      next_quo = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) sitting beside the EX-stage ALU.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              issue request (accepted only in IDLE, without kill)
//   funct3             RV32M op select
//   rs1_val, rs2_val   operands A and B
//   rd_in              destination register of the issued op
//   kill               flush: in-flight op is dropped, nothing is written
//   busy               stall request (high while multiplying or dividing)
//   done               one-cycle result-valid pulse
//   reg_write          write strobe, done with a non-zero rd_out
//   rd_out, result     destination and value of the last completed op;
//                      held until the next completion
//
// Handshake: start is a one-cycle request sampled at a rising edge; the
// unit has no ready output, so an issuer must hold the pipeline while busy
// is high and re-present a start that lands outside IDLE. done is a
// registered pulse raised on the edge that leaves DONE, so the result
// reaches the EX/MEM register in the same cycle as done.
//
// Latency from the accepting edge E0: multiply done after E2, special
// divide (divide by zero, signed overflow) after E1, normal divide after
// E(DIV_ITERS+2).
//
// Optional build macro MULDIV_EARLY_OUT_EN: adds a CHK state that
// compares the registered dividend and divisor magnitudes and completes
// the divide without iterating when |dividend| < |divisor|.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int DIV_ITERS = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic            reg_write,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV_ITERS);

  state_e state;
  state_e state_next;

  logic [XLEN-1:0] a_q;      // raw operand A
  logic [XLEN-1:0] b_q;      // raw operand B
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rem_q;    // partial remainder
  logic [XLEN-1:0] quo_q;    // dividend magnitude, becomes the quotient
  logic [XLEN-1:0] dvs_q;    // divisor magnitude
  logic [XLEN-1:0] res_q;    // result staged for the DONE edge
  logic [CW-1:0]   cnt_q;

  // Issue-side decode on the raw inputs
  logic            accept;
  logic            in_signed;
  logic            in_rem;
  logic            div_by_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  // Multiply datapath
  logic                   ext_a;
  logic                   ext_b;
  logic signed [2*XLEN-1:0] mul_a;
  logic signed [2*XLEN-1:0] mul_b;
  logic signed [2*XLEN-1:0] prod;

  // Divide datapath
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;

`ifdef MULDIV_EARLY_OUT_EN
  logic early;
  assign early = (quo_q < dvs_q);
`endif

  // --------------------------------------------------------------------
  // Issue decode
  // --------------------------------------------------------------------
  assign accept      = start && !kill && (state == IDLE);
  assign in_signed   = is_signed_div(funct3);
  assign in_rem      = funct3[1];
  assign div_by_zero = (rs2_val == '0);
  assign div_ovf     = in_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                       && (rs2_val == '1);
  assign special     = div_by_zero || div_ovf;

  // Divide-by-zero: quotient all ones, remainder = dividend.
  // Signed overflow: quotient = dividend (0x80000000), remainder 0.
  always_comb begin
    special_res = '0;
    if (div_by_zero) begin
      special_res = in_rem ? rs1_val : '1;
    end else begin
      special_res = in_rem ? '0 : rs1_val;
    end
  end

  // --------------------------------------------------------------------
  // Multiply: 33x33 signed product, computed in 2*XLEN bits because only
  // those bits are ever selected.
  // --------------------------------------------------------------------
  assign ext_a = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1];
  assign ext_b = (op_q == OP_MULH) && b_q[XLEN-1];
  assign mul_a = {{XLEN{ext_a}}, a_q};
  assign mul_b = {{XLEN{ext_b}}, b_q};
  assign prod  = mul_a * mul_b;

  // --------------------------------------------------------------------
  // Divide: one restoring step per DIV cycle, then sign correction.
  // --------------------------------------------------------------------
  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  assign q_neg   = is_signed_div(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign r_neg   = is_signed_div(op_q) && a_q[XLEN-1];
  assign quo_fix = q_neg ? -quo_q : quo_q;
  assign rem_fix = r_neg ? -rem_q : rem_q;
  assign div_res = op_q[1] ? rem_fix : quo_fix;

  // --------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!funct3[2]) begin
            state_next = MUL;
          end else if (special) begin
            state_next = DONE;
          end else begin
`ifdef MULDIV_EARLY_OUT_EN
            state_next = CHK;
`else
            state_next = DIV;
`endif
          end
        end
      end
      MUL:  state_next = DONE;
      DIV:  state_next = (cnt_q == LAST_CNT) ? DONE : DIV;
`ifdef MULDIV_EARLY_OUT_EN
      CHK:  state_next = early ? DONE : DIV;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A flush always wins. A DONE-cycle result was produced before the
    // flush, so the done register below still reports it.
    if (kill) begin
      state_next = IDLE;
    end
  end

  // CHK stalls the pipeline like the iterating states: the op is still
  // in flight and a new issue would be dropped.
`ifdef MULDIV_EARLY_OUT_EN
  assign busy = (state == MUL) || (state == DIV) || (state == CHK);
`else
  assign busy = (state == MUL) || (state == DIV);
`endif

  // --------------------------------------------------------------------
  // Datapath and outputs
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      rd_out    <= '0;
      result    <= '0;
    end else begin
      done      <= (state == DONE);
      reg_write <= (state == DONE) && (rd_q != 5'd0);
      if (state == DONE) begin
        result <= res_q;
        rd_out <= rd_q;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= funct3;
            rd_q  <= rd_in;
            a_q   <= rs1_val;
            b_q   <= rs2_val;
            rem_q <= '0;
            quo_q <= magnitude(rs1_val, in_signed);
            dvs_q <= magnitude(rs2_val, in_signed);
            cnt_q <= '0;
            // Only kept when the op turns out special; overwritten later
            // for every other op.
            res_q <= special_res;
          end
        end
        MUL: begin
          res_q <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        DIV: begin
          if (cnt_q != LAST_CNT) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            res_q <= div_res;
          end
        end
`ifdef MULDIV_EARLY_OUT_EN
        CHK: begin
          // Quotient 0; remainder is the dividend with its own sign.
          if (early) begin
            res_q <= op_q[1] ? a_q : '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
